// File: rtl/axis_fifo_pkg.sv
// Shared types and constants for the AXI-Stream FIFO test infrastructure:
// frame checker FSM states, error bit positions and the backpressure LFSR.
package axis_fifo_pkg;

  typedef enum logic {SOF, BODY} chk_state_t;

  // Bit positions inside the per-beat error vector / error_status
  localparam int ERR_DATA       = 0;
  localparam int ERR_LAST_EARLY = 1;
  localparam int ERR_LAST_MISS  = 2;
  localparam int ERR_KEEP       = 3;
  localparam int ERR_ID         = 4;
  localparam int ERR_USER       = 5;
  localparam int ERR_W          = 6;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // One step of the x^16+x^14+x^13+x^11+1 Fibonacci LFSR (right-shifting form)
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

endpackage

// File: rtl/axis_ready_gen.sv
// Programmable backpressure source for the frame checker. The output depends
// only on registered state and the mode select, never on tvalid.
module axis_ready_gen
  import axis_fifo_pkg::*;
(
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       enable,
  input  logic [1:0] ready_mode,
  output logic       gen
);

  logic [15:0] lfsr_q, lfsr_d;
  logic        alt_q, alt_d;
  logic        live_q, live_d;

  // Next state: LFSR advances on enabled cycles; the alternating phase is
  // parked at 1 outside mode 2 so that mode 2 always opens with a ready cycle.
  always_comb begin
    lfsr_d = enable ? lfsr_step(lfsr_q) : lfsr_q;
    live_d = 1'b1;
    alt_d  = alt_q;
    if (ready_mode != 2'd2) begin
      alt_d = 1'b1;
    end else if (enable) begin
      alt_d = ~alt_q;
    end
  end

  // State registers; live_q keeps gen low while and just after reset
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lfsr_q <= LFSR_SEED;
      alt_q  <= 1'b1;
      live_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      alt_q  <= alt_d;
      live_q <= live_d;
    end
  end

  // Mode mux: always / LFSR ~75% / alternate / never
  always_comb begin
    unique case (ready_mode)
      2'd0:    gen = live_q;
      2'd1:    gen = live_q & (lfsr_q[0] | lfsr_q[1]);
      2'd2:    gen = live_q & alt_q;
      default: gen = 1'b0;
    endcase
  end

endmodule

// File: rtl/axis_frame_checker.sv
// AXI-Stream sink that checks an incrementing-byte, fixed-length frame pattern
// with stable tid/tdest and zero tuser, and keeps frame/beat/error statistics.
module axis_frame_checker
  import axis_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int KEEP_ENABLE = 1,
  parameter int LAST_ENABLE = 1,
  parameter int ID_ENABLE   = 1,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_ENABLE = 1,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1,
  parameter int FRAME_LEN   = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [1:0]            ready_mode,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [31:0]           frame_count,
  output logic [31:0]           beat_count,
  output logic [15:0]           error_count,
  output logic [ERR_W-1:0]      error_status
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic                  gen;
  logic                  fire;
  chk_state_t            state_q, state_d;
  logic [IDX_W-1:0]      beat_idx_q, beat_idx_d;
  logic [7:0]            exp_byte_q, exp_byte_d;
  logic [ID_WIDTH-1:0]   tid_q, tid_d;
  logic [DEST_WIDTH-1:0] tdest_q, tdest_d;
  logic [31:0]           frame_count_q, frame_count_d;
  logic [31:0]           beat_count_q, beat_count_d;
  logic [15:0]           error_count_q, error_count_d;
  logic [ERR_W-1:0]      error_status_q, error_status_d;

  logic [KEEP_WIDTH-1:0] keep;
  logic [KEEP_WIDTH:0]   keep_inc;
  logic                  at_last, eof, mism;
  logic [7:0]            nbytes, last_byte, lane;
  logic [ERR_W-1:0]      err;

  axis_ready_gen u_ready_gen (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .enable     (enable),
    .ready_mode (ready_mode),
    .gen        (gen)
  );

  assign s_axis_tready = enable & ~clear & gen;
  assign fire          = s_axis_tvalid & s_axis_tready;

  // Per-beat checks: lane data, framing, tkeep shape, sideband stability
  always_comb begin
    keep = (KEEP_ENABLE != 0) ? s_axis_tkeep : '1;
    keep_inc = {1'b0, keep} + 1'b1;
    at_last  = (beat_idx_q == LAST_IDX);
    eof      = at_last | ((LAST_ENABLE != 0) & s_axis_tlast);

    nbytes    = 8'd0;
    last_byte = 8'd0;
    mism      = 1'b0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      lane = s_axis_tdata[8*i +: 8];
      if (keep[i]) begin
        nbytes    = nbytes + 8'd1;
        last_byte = lane;
        if (lane != exp_byte_q + 8'(i)) mism = 1'b1;
      end
    end

    err = '0;
    err[ERR_DATA] = mism;
    if (LAST_ENABLE != 0) begin
      err[ERR_LAST_EARLY] = s_axis_tlast & ~at_last;
      err[ERR_LAST_MISS]  = ~s_axis_tlast & at_last;
    end
    // Legal shapes are 0..01..1; a partial shape is only allowed on the frame's last beat
    err[ERR_KEEP] = (keep == '0) | ((keep_inc & {1'b0, keep}) != '0) | (~(&keep) & ~eof);
    if (state_q == BODY) begin
      err[ERR_ID] = ((ID_ENABLE != 0) && (s_axis_tid != tid_q)) ||
                    ((DEST_ENABLE != 0) && (s_axis_tdest != tdest_q));
    end
    if (USER_ENABLE != 0) err[ERR_USER] = (s_axis_tuser != '0);
  end

  // Next-state: clear beats any transfer; otherwise advance on an accepted beat
  always_comb begin
    state_d        = state_q;
    beat_idx_d     = beat_idx_q;
    exp_byte_d     = exp_byte_q;
    tid_d          = tid_q;
    tdest_d        = tdest_q;
    frame_count_d  = frame_count_q;
    beat_count_d   = beat_count_q;
    error_count_d  = error_count_q;
    error_status_d = error_status_q;
    if (clear) begin
      state_d        = SOF;
      beat_idx_d     = '0;
      exp_byte_d     = 8'd0;
      frame_count_d  = 32'd0;
      beat_count_d   = 32'd0;
      error_count_d  = 16'd0;
      error_status_d = '0;
    end else if (fire) begin
      beat_count_d   = beat_count_q + 32'd1;
      error_status_d = error_status_q | err;
      if ((err != '0) && (error_count_q != 16'hFFFF)) error_count_d = error_count_q + 16'd1;
      // A mismatch resyncs to the received stream so one bad byte does not cascade
      exp_byte_d = mism ? (last_byte + 8'd1) : (exp_byte_q + nbytes);
      if (state_q == SOF) begin
        tid_d   = s_axis_tid;
        tdest_d = s_axis_tdest;
      end
      if (eof) begin
        frame_count_d = frame_count_q + 32'd1;
        beat_idx_d    = '0;
        state_d       = SOF;
      end else begin
        beat_idx_d = beat_idx_q + 1'b1;
        state_d    = BODY;
      end
    end
  end

  // Checker state registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= SOF;
      beat_idx_q     <= '0;
      exp_byte_q     <= 8'd0;
      tid_q          <= '0;
      tdest_q        <= '0;
      frame_count_q  <= 32'd0;
      beat_count_q   <= 32'd0;
      error_count_q  <= 16'd0;
      error_status_q <= '0;
    end else begin
      state_q        <= state_d;
      beat_idx_q     <= beat_idx_d;
      exp_byte_q     <= exp_byte_d;
      tid_q          <= tid_d;
      tdest_q        <= tdest_d;
      frame_count_q  <= frame_count_d;
      beat_count_q   <= beat_count_d;
      error_count_q  <= error_count_d;
      error_status_q <= error_status_d;
    end
  end

  assign frame_count  = frame_count_q;
  assign beat_count   = beat_count_q;
  assign error_count  = error_count_q;
  assign error_status = error_status_q;

endmodule

// File: tb/tb_axis_frame_checker.sv
// Directed bench for axis_frame_checker (32-bit data, 4-beat frames).
module tb_axis_frame_checker;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic        clear;
  logic [1:0]  ready_mode;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [7:0]  tid;
  logic [7:0]  tdest;
  logic [0:0]  tuser;
  logic [31:0] frame_count;
  logic [31:0] beat_count;
  logic [15:0] error_count;
  logic [5:0]  error_status;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] lfsr_m;

  always #5 aclk = ~aclk;

  axis_frame_checker #(.DATA_WIDTH(32), .FRAME_LEN(4)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .enable        (enable),
    .clear         (clear),
    .ready_mode    (ready_mode),
    .s_axis_tdata  (tdata),
    .s_axis_tkeep  (tkeep),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .s_axis_tlast  (tlast),
    .s_axis_tid    (tid),
    .s_axis_tdest  (tdest),
    .s_axis_tuser  (tuser),
    .frame_count   (frame_count),
    .beat_count    (beat_count),
    .error_count   (error_count),
    .error_status  (error_status)
  );

  // Reference LFSR: seed 0xACE1, taps x^16+x^14+x^13+x^11+1, steps on enabled cycles
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) lfsr_m <= 16'hACE1;
    else if (enable) lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
  end

  function automatic logic [31:0] pat(input int j);
    return {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic counts(input string pfx, input logic [31:0] f, input logic [31:0] b,
                        input logic [31:0] e, input logic [31:0] s);
    chk({pfx, "_frames"}, frame_count, f);
    chk({pfx, "_beats"},  beat_count,  b);
    chk({pfx, "_errors"}, {16'd0, error_count}, e);
    chk({pfx, "_status"}, {26'd0, error_status}, s);
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
    @(negedge aclk);
    tvalid = 1'b1;
    tdata  = d;
    tkeep  = k;
    tlast  = l;
  endtask

  task automatic idle();
    @(negedge aclk);
    tvalid = 1'b0;
    tlast  = 1'b0;
    #1;
  endtask

  task automatic do_clear();
    @(negedge aclk);
    tvalid = 1'b0;
    clear  = 1'b1;
    @(negedge aclk);
    clear = 1'b0;
    #1;
  endtask

  initial begin
    aresetn = 1'b0; enable = 1'b0; clear = 1'b0; ready_mode = 2'd0;
    tdata = '0; tkeep = 4'hF; tvalid = 1'b0; tlast = 1'b0;
    tid = 8'h12; tdest = 8'h34; tuser = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    chk("reset_tready", {31'd0, tready}, 32'd0);
    counts("reset", 0, 0, 0, 0);

    @(negedge aclk);
    aresetn = 1'b1;
    enable  = 1'b1;
    @(negedge aclk);
    #1;
    chk("mode0_tready", {31'd0, tready}, 32'd1);

    // Clean frame
    send(32'h03020100, 4'hF, 1'b0);
    send(32'h07060504, 4'hF, 1'b0);
    send(32'h0B0A0908, 4'hF, 1'b0);
    send(32'h0F0E0D0C, 4'hF, 1'b1);
    idle();
    counts("clean", 1, 4, 0, 0);

    do_clear();
    counts("clear1", 0, 0, 0, 0);

    // Corrupted byte then resync
    send(32'h03020100, 4'hF, 1'b0);
    send(32'h070605FF, 4'hF, 1'b0);
    send(32'h0B0A0908, 4'hF, 1'b0);
    send(32'h0F0E0D0C, 4'hF, 1'b1);
    idle();
    counts("data_err", 1, 4, 1, 32'h01);

    // Early tlast, then a new frame that is missing its tlast
    do_clear();
    send(32'h03020100, 4'hF, 1'b0);
    send(32'h07060504, 4'hF, 1'b1);
    idle();
    counts("early_last", 1, 2, 1, 32'h02);
    send(32'h0B0A0908, 4'hF, 1'b0);
    send(32'h0F0E0D0C, 4'hF, 1'b0);
    send(32'h13121110, 4'hF, 1'b0);
    send(32'h17161514, 4'hF, 1'b0);
    idle();
    counts("miss_last", 2, 6, 2, 32'h06);

    // tkeep shapes: partial and non-contiguous on non-final beats, partial final is legal
    do_clear();
    send(32'h03020100, 4'b0111, 1'b0);
    send(32'h00050003, 4'b0101, 1'b0);
    idle();
    counts("keep_bad", 0, 2, 2, 32'h08);
    send(32'h08070605, 4'hF, 1'b0);
    send(32'h00000A09, 4'b0011, 1'b1);
    idle();
    counts("keep_final", 1, 4, 2, 32'h08);

    // tid change and nonzero tuser
    do_clear();
    send(32'h03020100, 4'hF, 1'b0);
    tid = 8'h55;
    send(32'h07060504, 4'hF, 1'b0);
    @(negedge aclk);
    tid = 8'h12; tuser = 1'b1;
    tdata = 32'h0B0A0908;
    send(32'h0F0E0D0C, 4'hF, 1'b1);
    tuser = 1'b0;
    idle();
    counts("side", 1, 4, 2, 32'h30);

    // Mode 2: alternating ready with tvalid held high
    do_clear();
    for (int k = 0; k < 8; k++) begin
      @(negedge aclk);
      if (k == 0) ready_mode = 2'd2;
      tvalid = 1'b1;
      tdata  = pat(k / 2);
      tkeep  = 4'hF;
      tlast  = (k / 2 == 3);
      #1;
      chk("mode2_tready", {31'd0, tready}, {31'd0, (k % 2 == 0)});
    end
    idle();
    counts("mode2", 1, 4, 0, 0);

    // Mode 1: LFSR-driven ready
    @(negedge aclk);
    ready_mode = 2'd1;
    for (int k = 0; k < 8; k++) begin
      @(negedge aclk);
      #1;
      chk("mode1_tready", {31'd0, tready}, {31'd0, lfsr_m[0] | lfsr_m[1]});
    end

    // Mode 3: never ready, counters frozen
    @(negedge aclk);
    ready_mode = 2'd3;
    tvalid = 1'b1; tdata = pat(4); tkeep = 4'hF; tlast = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      #1;
      chk("mode3_tready", {31'd0, tready}, 32'd0);
    end
    chk("mode3_beats", beat_count, 32'd4);

    // Clear with tvalid high in mode 0: no acceptance, counters zeroed
    @(negedge aclk);
    ready_mode = 2'd0;
    clear = 1'b1;
    #1;
    chk("clear_tready", {31'd0, tready}, 32'd0);
    @(negedge aclk);
    clear = 1'b0;
    tvalid = 1'b0;
    #1;
    counts("clear_valid", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
